cic_comb_chain: RTL and testbench

Parametrised, multi-channel comb section for the decimating CIC filter: N cascaded comb stages, each computing y[n] = x[n] − x[n−M] per channel. It sits after the integrator chain and rate-change decimator, at the low-rate side. CH independent channels arrive time-interleaved on one bus. Every stage is pipelined and driven by a valid strobe, so one sample per clock is sustained.

---
 rtl/cic_comb_chain.sv | 141 ++++++++++++++
 tb/tb_cic_comb_chain.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_comb_chain.sv
// cic_comb_chain: multi-channel comb section of a decimating CIC filter.
// N cascaded comb stages compute y[n] = x[n] - x[n-M] for each of CH
// channels that arrive time-interleaved on one bus. Each stage is one
// register deep, so latency is N clocks and one sample per clock is sustained.
// Optional feature macro: CIC_COMB_SEQCHK_EN enables channel-order checking
// and counter resync (seq_err_o). Without it the internal channel counter
// tags the samples and ch_i is ignored.
module cic_comb_chain #(
  parameter int DW  = 22,
  parameter int N   = 3,
  parameter int M   = 1,
  parameter int CH  = 1,
  parameter int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  valid_i,
  input  logic [CHW-1:0]        ch_i,
  input  logic signed [DW-1:0]  data_i,
  output logic                  valid_o,
  output logic [CHW-1:0]        ch_o,
  output logic signed [DW-1:0]  data_o,
  output logic                  seq_err_o
);

  // Each stage keeps M samples of history for every channel; with strict
  // round-robin arrival the oldest word is the same channel M samples ago.
  localparam int              DEPTH   = M * CH;
  localparam logic [CHW-1:0]  LAST_CH = CHW'(CH - 1);

  logic [CHW-1:0] exp_ch_reg;
  logic [CHW-1:0] exp_ch_next;
  logic [CHW-1:0] in_tag;

  // Per-stage output registers; element gi is written only by stage gi.
  logic signed [DW-1:0] stage_data [N];
  logic                 stage_valid [N];
  logic [CHW-1:0]       stage_ch [N];

`ifdef CIC_COMB_SEQCHK_EN
  logic [CHW:0] ch_inc;
  logic         mismatch;
  logic         seq_err_reg;

  assign ch_inc   = {1'b0, ch_i} + 1'b1;
  // A single channel has nothing to order, so its tag is never compared.
  assign mismatch = (CH > 1) && (ch_i != exp_ch_reg);
  assign in_tag   = (CH > 1) ? ch_i : '0;

  // Next expected channel: follows ch_i + 1, which both advances the count
  // on a correct sample and resyncs after an out-of-order one.
  always_comb begin
    exp_ch_next = CHW'(int'(ch_inc) % CH);
  end

  // Error flag is a one-cycle pulse after an out-of-order valid sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seq_err_reg <= 1'b0;
    end else if (clr_i) begin
      seq_err_reg <= 1'b0;
    end else begin
      seq_err_reg <= valid_i && mismatch;
    end
  end

  assign seq_err_o = seq_err_reg;
`else
  logic unused_ch_i;

  assign unused_ch_i = ^ch_i;
  assign in_tag      = exp_ch_reg;
  assign seq_err_o   = 1'b0;

  // Free-running round-robin count, no resync possible without checking.
  always_comb begin
    exp_ch_next = (exp_ch_reg == LAST_CH) ? '0 : exp_ch_reg + 1'b1;
  end
`endif

  // Expected-channel counter advances once per accepted input sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_ch_reg <= '0;
    end else if (clr_i) begin
      exp_ch_reg <= '0;
    end else if (valid_i) begin
      exp_ch_reg <= exp_ch_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      logic signed [DW-1:0] din;
      logic                 vin;
      logic [CHW-1:0]       cin;
      logic signed [DW-1:0] dly [DEPTH];

      if (gi == 0) begin : g_first
        assign din = data_i;
        assign vin = valid_i;
        assign cin = in_tag;
      end else begin : g_chain
        assign din = stage_data[gi-1];
        assign vin = stage_valid[gi-1];
        assign cin = stage_ch[gi-1];
      end

      // Comb stage: subtract the delayed word (mod 2^DW, wrap intended)
      // and shift the history line only when a sample is present.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < DEPTH; i++) dly[i] <= '0;
          stage_data[gi]  <= '0;
          stage_valid[gi] <= 1'b0;
          stage_ch[gi]    <= '0;
        end else if (clr_i) begin
          for (int i = 0; i < DEPTH; i++) dly[i] <= '0;
          stage_data[gi]  <= '0;
          stage_valid[gi] <= 1'b0;
          stage_ch[gi]    <= '0;
        end else begin
          stage_valid[gi] <= vin;
          if (vin) begin
            stage_data[gi] <= din - dly[DEPTH-1];
            stage_ch[gi]   <= cin;
            dly[0]         <= din;
            for (int i = 1; i < DEPTH; i++) dly[i] <= dly[i-1];
          end
        end
      end
    end
  endgenerate

  assign data_o  = stage_data[N-1];
  assign valid_o = stage_valid[N-1];
  assign ch_o    = stage_ch[N-1];

endmodule

// File: tb/tb_cic_comb_chain.sv
// tb_cic_comb_chain: directed test of cic_comb_chain in several
// configurations (single stage, 3-stage impulse, 8-bit wrap, 2 and 4
// interleaved channels, clear and asynchronous reset mid-stream).
module tb_cic_comb_chain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // A: DW=22 N=1 M=1 CH=1
  logic a_clr = 0, a_valid_i = 0, a_valid, a_err;
  logic [0:0] a_ch_i = '0, a_ch;
  logic signed [21:0] a_data_i = '0, a_data;
  // B: DW=22 N=3 M=2 CH=1
  logic b_clr = 0, b_valid_i = 0, b_valid, b_err;
  logic [0:0] b_ch_i = '0, b_ch;
  logic signed [21:0] b_data_i = '0, b_data;
  // C: DW=8 N=1 M=1 CH=1
  logic c_clr = 0, c_valid_i = 0, c_valid, c_err;
  logic [0:0] c_ch_i = '0, c_ch;
  logic signed [7:0] c_data_i = '0, c_data;
  // D: DW=22 N=1 M=1 CH=2
  logic d_clr = 0, d_valid_i = 0, d_valid, d_err;
  logic [0:0] d_ch_i = '0, d_ch;
  logic signed [21:0] d_data_i = '0, d_data;
  // E: DW=22 N=1 M=1 CH=4
  logic e_clr = 0, e_valid_i = 0, e_valid, e_err;
  logic [1:0] e_ch_i = '0, e_ch;
  logic signed [21:0] e_data_i = '0, e_data;

  cic_comb_chain #(.DW(22), .N(1), .M(1), .CH(1)) u_a (
    .clk_i(clk), .rst_i(rst), .clr_i(a_clr), .valid_i(a_valid_i), .ch_i(a_ch_i),
    .data_i(a_data_i), .valid_o(a_valid), .ch_o(a_ch), .data_o(a_data), .seq_err_o(a_err));
  cic_comb_chain #(.DW(22), .N(3), .M(2), .CH(1)) u_b (
    .clk_i(clk), .rst_i(rst), .clr_i(b_clr), .valid_i(b_valid_i), .ch_i(b_ch_i),
    .data_i(b_data_i), .valid_o(b_valid), .ch_o(b_ch), .data_o(b_data), .seq_err_o(b_err));
  cic_comb_chain #(.DW(8), .N(1), .M(1), .CH(1)) u_c (
    .clk_i(clk), .rst_i(rst), .clr_i(c_clr), .valid_i(c_valid_i), .ch_i(c_ch_i),
    .data_i(c_data_i), .valid_o(c_valid), .ch_o(c_ch), .data_o(c_data), .seq_err_o(c_err));
  cic_comb_chain #(.DW(22), .N(1), .M(1), .CH(2)) u_d (
    .clk_i(clk), .rst_i(rst), .clr_i(d_clr), .valid_i(d_valid_i), .ch_i(d_ch_i),
    .data_i(d_data_i), .valid_o(d_valid), .ch_o(d_ch), .data_o(d_data), .seq_err_o(d_err));
  cic_comb_chain #(.DW(22), .N(1), .M(1), .CH(4)) u_e (
    .clk_i(clk), .rst_i(rst), .clr_i(e_clr), .valid_i(e_valid_i), .ch_i(e_ch_i),
    .data_i(e_data_i), .valid_o(e_valid), .ch_o(e_ch), .data_o(e_data), .seq_err_o(e_err));

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance to just after the next rising edge; outputs are sampled and
  // inputs driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int imp [9] = '{1, 0, -3, 0, 3, 0, -1, 0, 0};

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst a_valid", longint'(a_valid), 0);
    check("rst a_data", longint'(a_data), 0);
    check("rst b_data", longint'(b_data), 0);
    check("rst d_ch", longint'(d_ch), 0);
    check("rst e_err", longint'(e_err), 0);

    // Single-stage step: 5 held, valid every cycle -> 5 then 0
    a_valid_i = 1'b1;
    a_data_i  = 22'sd5;
    tick();
    check("step valid", longint'(a_valid), 1);
    check("step first", longint'(a_data), 5);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("step valid", longint'(a_valid), 1);
      check("step settled", longint'(a_data), 0);
    end
    a_valid_i = 1'b0;

    // Impulse through N=3, M=2: 1,0,-3,0,3,0,-1,0 after 3 clocks
    b_valid_i = 1'b1;
    b_data_i  = 22'sd1;
    tick();
    b_data_i = 22'sd0;
    check("imp lat1 valid", longint'(b_valid), 0);
    tick();
    check("imp lat2 valid", longint'(b_valid), 0);
    tick();
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      check("imp valid", longint'(b_valid), 1);
      check($sformatf("imp[%0d]", k), longint'(b_data), longint'(imp[k]));
    end
    b_valid_i = 1'b0;

    // 8-bit wrap-around: -128 then 127 -> -128, -1
    c_valid_i = 1'b1;
    c_data_i  = 8'sh80;
    tick();
    check("wrap first", longint'(c_data), -128);
    c_data_i = 8'sh7f;
    tick();
    check("wrap second", longint'(c_data), -1);
    c_valid_i = 1'b0;

    // Two channels on alternate cycles: ch0 held 10, ch1 ramps by 3
    for (int k = 0; k < 8; k++) begin
      d_valid_i = 1'b1;
      d_ch_i    = 1'(k % 2);
      d_data_i  = (k % 2 == 0) ? 22'sd10 : 22'(3 * (k / 2));
      tick();
      check("ilv valid", longint'(d_valid), 1);
      check("ilv ch", longint'(d_ch), longint'(k % 2));
      check($sformatf("ilv data k%0d", k), longint'(d_data),
            (k % 2 == 0) ? ((k == 0) ? 10 : 0) : ((k == 1) ? 0 : 3));
      d_valid_i = 1'b0;
      tick();
      check("ilv gap valid", longint'(d_valid), 0);
    end

    // Channel order 0,1,3,0 on four channels
    e_valid_i = 1'b1;
    e_ch_i = 2'd0; e_data_i = 22'sd1;
    tick();
    check("seq err0", longint'(e_err), 0);
    check("seq ch0", longint'(e_ch), 0);
    check("seq data0", longint'(e_data), 1);
    e_ch_i = 2'd1; e_data_i = 22'sd2;
    tick();
    check("seq err1", longint'(e_err), 0);
    check("seq ch1", longint'(e_ch), 1);
    e_ch_i = 2'd3; e_data_i = 22'sd3;
    tick();
`ifdef CIC_COMB_SEQCHK_EN
    check("seq err on ch3", longint'(e_err), 1);
    check("seq ch3", longint'(e_ch), 3);
`else
    check("seq err on ch3", longint'(e_err), 0);
    check("seq ch3", longint'(e_ch), 2);
`endif
    check("seq data3", longint'(e_data), 3);
    e_ch_i = 2'd0; e_data_i = 22'sd4;
    tick();
    check("seq err after resync", longint'(e_err), 0);
`ifdef CIC_COMB_SEQCHK_EN
    check("seq ch after resync", longint'(e_ch), 0);
`else
    check("seq ch after resync", longint'(e_ch), 3);
`endif
    e_valid_i = 1'b0;
    tick();
    check("seq err single pulse", longint'(e_err), 0);

    // Synchronous clear mid-stream on two channels
    d_valid_i = 1'b1;
    d_ch_i = 1'b0; d_data_i = 22'sd20; tick();
    d_ch_i = 1'b1; d_data_i = 22'sd30; tick();
    d_ch_i = 1'b0; d_data_i = 22'sd25; tick();
    d_clr = 1'b1;
    d_ch_i = 1'b1; d_data_i = 22'sd99;
    tick();
    d_clr = 1'b0;
    check("clr valid", longint'(d_valid), 0);
    check("clr data", longint'(d_data), 0);
    check("clr ch", longint'(d_ch), 0);
    d_ch_i = 1'b0; d_data_i = 22'sd7;
    tick();
    check("clr ch0 7", longint'(d_data), 7);
    check("clr ch0 tag", longint'(d_ch), 0);
    d_ch_i = 1'b1; d_data_i = 22'sd4;
    tick();
    check("clr ch1 4", longint'(d_data), 4);
    check("clr ch1 tag", longint'(d_ch), 1);

    // Asynchronous reset between edges
    d_ch_i = 1'b0; d_data_i = 22'sd50; tick();
    d_ch_i = 1'b1; d_data_i = 22'sd60; tick();
    check("pre-rst ch1", longint'(d_data), 56);
    d_valid_i = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("arst d_valid", longint'(d_valid), 0);
    check("arst d_data", longint'(d_data), 0);
    check("arst c_data", longint'(c_data), 0);
    #2;
    rst = 1'b0;
    d_valid_i = 1'b1;
    d_ch_i = 1'b0; d_data_i = 22'sd7;
    tick();
    check("arst ch0 7", longint'(d_data), 7);
    d_ch_i = 1'b1; d_data_i = 22'sd5;
    tick();
    check("arst ch1 5", longint'(d_data), 5);
    d_valid_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
